// File: rtl/lr_prod_accum.sv
// Per-track accumulator for signed products: sums beats until prod_last with saturation,
// a saturating beat count and a sticky overflow flag. Results leave through a 1-deep valid/ready register.
module lr_prod_accum #(
    parameter int PROD_W = 31,
    parameter int SUM_W  = 38,
    parameter int CNT_W  = 4
) (
    input  logic                     ap_clk,
    input  logic                     ap_rst_n,
    input  logic signed [PROD_W-1:0] prod_in,
    input  logic                     prod_valid,
    input  logic                     prod_last,
    output logic                     prod_ready,
    output logic signed [SUM_W-1:0]  sum_out,
    output logic [CNT_W-1:0]         cnt_out,
    output logic                     ovf_out,
    output logic                     sum_valid,
    input  logic                     sum_ready
);

    typedef enum logic {IDLE, ACC} state_e;

    localparam logic signed [SUM_W-1:0] SUM_MAX = {1'b0, {(SUM_W-1){1'b1}}};
    localparam logic signed [SUM_W-1:0] SUM_MIN = {1'b1, {(SUM_W-1){1'b0}}};
    localparam logic [CNT_W-1:0]        CNT_MAX = '1;

    state_e                   state_q, state_d;
    logic signed [SUM_W-1:0]  acc_q, acc_d;
    logic [CNT_W-1:0]         cnt_q, cnt_d;
    logic                     ovf_q, ovf_d;
    logic signed [SUM_W-1:0]  sum_q, sum_d;
    logic [CNT_W-1:0]         cnt_out_q, cnt_out_d;
    logic                     ovf_out_q, ovf_out_d;
    logic                     sum_valid_q, sum_valid_d;

    logic                     accept;
    logic signed [SUM_W-1:0]  prod_ext;
    logic [SUM_W:0]           sum_wide;
    logic                     add_ovf;
    logic signed [SUM_W-1:0]  sum_sat;
    logic                     cnt_full;
    logic [CNT_W-1:0]         cnt_inc;
    logic                     ovf_new;

    // The output register is free when empty or being drained this cycle.
    assign prod_ready = !sum_valid_q || sum_ready;
    assign accept     = prod_valid && prod_ready;

    // Adding in SUM_W+1 bits exposes signed overflow as a mismatch of the two top bits.
    assign prod_ext = {{(SUM_W-PROD_W){prod_in[PROD_W-1]}}, prod_in};
    assign sum_wide = {acc_q[SUM_W-1], acc_q} + {prod_ext[SUM_W-1], prod_ext};
    assign add_ovf  = sum_wide[SUM_W] != sum_wide[SUM_W-1];
    assign sum_sat  = !add_ovf ? sum_wide[SUM_W-1:0] : (sum_wide[SUM_W] ? SUM_MIN : SUM_MAX);
    assign cnt_full = cnt_q == CNT_MAX;
    assign cnt_inc  = cnt_full ? cnt_q : cnt_q + CNT_W'(1);
    assign ovf_new  = ovf_q || add_ovf || cnt_full;

    // NOTE: every flop here, including the result register, sits on the async reset so a
    // partial track and any pending result vanish together; <= keeps all updates simultaneous.
    always_ff @(posedge ap_clk or negedge ap_rst_n) begin
        if (!ap_rst_n) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        if (accept) begin
            state_d = prod_last ? IDLE : ACC;
        end
    end

    // NOTE: each comb output takes a hold value first, so no path leaves one unassigned (no latch).
    always_comb begin
        acc_d       = acc_q;
        cnt_d       = cnt_q;
        ovf_d       = ovf_q;
        sum_d       = sum_q;
        cnt_out_d   = cnt_out_q;
        ovf_out_d   = ovf_out_q;
        sum_valid_d = sum_valid_q && !sum_ready;
        if (accept) begin
            if (prod_last) begin
                acc_d       = '0;
                cnt_d       = '0;
                ovf_d       = 1'b0;
                sum_d       = sum_sat;
                cnt_out_d   = cnt_inc;
                ovf_out_d   = ovf_new;
                sum_valid_d = 1'b1;
            end else begin
                acc_d = sum_sat;
                cnt_d = cnt_inc;
                ovf_d = ovf_new;
            end
        end
    end

    always_ff @(posedge ap_clk or negedge ap_rst_n) begin
        if (!ap_rst_n) begin
            acc_q       <= '0;
            cnt_q       <= '0;
            ovf_q       <= 1'b0;
            sum_q       <= '0;
            cnt_out_q   <= '0;
            ovf_out_q   <= 1'b0;
            sum_valid_q <= 1'b0;
        end else begin
            acc_q       <= acc_d;
            cnt_q       <= cnt_d;
            ovf_q       <= ovf_d;
            sum_q       <= sum_d;
            cnt_out_q   <= cnt_out_d;
            ovf_out_q   <= ovf_out_d;
            sum_valid_q <= sum_valid_d;
        end
    end

    assign sum_out   = sum_q;
    assign cnt_out   = cnt_out_q;
    assign ovf_out   = ovf_out_q;
    assign sum_valid = sum_valid_q;

endmodule

// File: tb/tb_lr_prod_accum.sv
// Directed bench for lr_prod_accum: default instance plus a SUM_W=32 instance for saturation.
// Expected results are queued at stimulus time; a negedge monitor pops them on each handshake.
module tb_lr_prod_accum;

    typedef struct {
        logic signed [37:0] sum;
        logic [3:0]         cnt;
        logic               ovf;
    } exp_t;

    localparam logic signed [30:0] P_MAX = 31'sh3fffffff;  // 2^30-1
    localparam logic signed [30:0] P_MIN = 31'sh40000000;  // -2^30

    logic               ap_clk = 1'b0;
    logic               ap_rst_n = 1'b1;
    logic signed [30:0] prod_in = '0;
    logic               prod_valid = 1'b0;
    logic               prod_last = 1'b0;
    logic               sum_ready = 1'b1;
    logic               sel = 1'b0;

    logic               v38, v32, rdy38, rdy32;
    logic signed [37:0] sum38;
    logic signed [31:0] sum32;
    logic [3:0]         cnt38, cnt32;
    logic               ovf38, ovf32, sv38, sv32;

    exp_t q38[$];
    exp_t q32[$];
    int   checks = 0;
    int   errors = 0;

    assign v38 = prod_valid && !sel;
    assign v32 = prod_valid && sel;

    always #5 ap_clk = ~ap_clk;

    lr_prod_accum dut (
        .ap_clk(ap_clk), .ap_rst_n(ap_rst_n), .prod_in(prod_in), .prod_valid(v38),
        .prod_last(prod_last), .prod_ready(rdy38), .sum_out(sum38), .cnt_out(cnt38),
        .ovf_out(ovf38), .sum_valid(sv38), .sum_ready(sum_ready)
    );

    lr_prod_accum #(.SUM_W(32)) dut32 (
        .ap_clk(ap_clk), .ap_rst_n(ap_rst_n), .prod_in(prod_in), .prod_valid(v32),
        .prod_last(prod_last), .prod_ready(rdy32), .sum_out(sum32), .cnt_out(cnt32),
        .ovf_out(ovf32), .sum_valid(sv32), .sum_ready(sum_ready)
    );

    task automatic check(input string name, input logic signed [63:0] act, input logic signed [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    task automatic sync();
        @(posedge ap_clk);
        #1;
    endtask

    // Presents one beat and returns once it has been accepted; waited counts stalled edges.
    task automatic send(input logic to32, input logic signed [30:0] v, input logic last, output int waited);
        logic ok;
        sel = to32;
        prod_in = v;
        prod_last = last;
        prod_valid = 1'b1;
        waited = 0;
        forever begin
            @(negedge ap_clk);
            ok = to32 ? rdy32 : rdy38;
            sync();
            if (ok) break;
            waited++;
            if (waited > 100) begin
                checks++;
                errors++;
                $display("FAIL send_timeout: beat %0d not accepted after %0d cycles", v, waited);
                break;
            end
        end
        prod_valid = 1'b0;
        prod_last = 1'b0;
    endtask

    task automatic push38(input logic signed [37:0] s, input logic [3:0] c, input logic o);
        exp_t e;
        e.sum = s; e.cnt = c; e.ovf = o;
        q38.push_back(e);
    endtask

    task automatic push32(input logic signed [37:0] s, input logic [3:0] c, input logic o);
        exp_t e;
        e.sum = s; e.cnt = c; e.ovf = o;
        q32.push_back(e);
    endtask

    // Monitor: a result is consumed on the edge following a negedge where valid and ready are both high.
    always @(negedge ap_clk) begin
        if (ap_rst_n) begin
            if (sv38 && sum_ready) begin
                if (q38.size() == 0) begin
                    checks++; errors++;
                    $display("FAIL unexpected_result38: got sum %0d expected none", sum38);
                end else begin
                    exp_t e;
                    e = q38.pop_front();
                    check("sum38", sum38, e.sum);
                    check("cnt38", cnt38, e.cnt);
                    check("ovf38", ovf38, e.ovf);
                end
            end
            if (sv32 && sum_ready) begin
                if (q32.size() == 0) begin
                    checks++; errors++;
                    $display("FAIL unexpected_result32: got sum %0d expected none", sum32);
                end else begin
                    exp_t e;
                    e = q32.pop_front();
                    check("sum32", sum32, e.sum);
                    check("cnt32", cnt32, e.cnt);
                    check("ovf32", ovf32, e.ovf);
                end
            end
        end
    end

    initial begin
        int w;
        // Asynchronous reset, checked before any clock edge.
        #1 ap_rst_n = 1'b0;
        #1;
        check("rst_sum_valid", sv38, 0);
        check("rst_prod_ready", rdy38, 1);
        check("rst_sum_out", sum38, 0);
        check("rst_cnt_out", cnt38, 0);
        check("rst_ovf_out", ovf38, 0);
        repeat (2) @(posedge ap_clk);
        #1 ap_rst_n = 1'b1;

        // 100, -30, 5: result one cycle after the last beat, valid for exactly one cycle.
        push38(75, 3, 0);
        send(0, 100, 0, w);
        send(0, -30, 0, w);
        send(0, 5, 1, w);
        @(negedge ap_clk);
        check("latency_valid", sv38, 1);
        @(negedge ap_clk);
        check("one_cycle_valid", sv38, 0);
        sync();

        // Single-beat track at the most negative product.
        push38(-38'sd1073741824, 1, 0);
        send(0, P_MIN, 1, w);

        // Sixteen beats of 1: count saturates at 15 and flags overflow.
        push38(16, 15, 1);
        for (int i = 0; i < 15; i++) send(0, 1, 0, w);
        send(0, 1, 1, w);

        // SUM_W=32: 2*(2^30-1) = 2^31-2 still fits, so it must not saturate.
        push32(38'sd2147483646, 2, 0);
        send(1, P_MAX, 0, w);
        send(1, P_MAX, 1, w);
        // A third beat pushes past 2^31-1: clamps high and flags overflow.
        push32(38'sd2147483647, 3, 1);
        for (int i = 0; i < 2; i++) send(1, P_MAX, 0, w);
        send(1, P_MAX, 1, w);
        // Three times -2^30 clamps low.
        push32(-38'sd2147483648, 3, 1);
        for (int i = 0; i < 2; i++) send(1, P_MIN, 0, w);
        send(1, P_MIN, 1, w);
        // Saturated partial sum continues from the clamp; ovf stays sticky within the track.
        push32(38'sd1073741823, 4, 1);
        for (int i = 0; i < 3; i++) send(1, P_MAX, 0, w);
        send(1, P_MIN, 1, w);
        // Next track starts clean.
        push32(5, 1, 0);
        send(1, 5, 1, w);

        // Backpressure: result held 5 cycles, input stalled, outputs stable.
        sum_ready = 1'b0;
        push38(11, 1, 0);
        send(0, 11, 1, w);
        repeat (5) begin
            @(negedge ap_clk);
            check("stall_prod_ready", rdy38, 0);
            check("stall_sum_valid", sv38, 1);
            check("stall_sum_out", sum38, 11);
            check("stall_cnt_out", cnt38, 1);
            sync();
        end
        // Drain and load the next result on the same edge.
        sum_ready = 1'b1;
        push38(22, 1, 0);
        send(0, 22, 1, w);
        check("b2b_no_wait", w, 0);
        @(negedge ap_clk);
        check("b2b_valid_kept", sv38, 1);
        sync();

        // Reset with a pending result clears sum_valid at once.
        sum_ready = 1'b0;
        send(0, 9, 1, w);
        @(negedge ap_clk);
        check("pending_before_rst", sv38, 1);
        ap_rst_n = 1'b0;
        #1;
        check("rst_clears_pending", sv38, 0);
        check("rst_prod_ready_pend", rdy38, 1);
        sync();
        ap_rst_n = 1'b1;
        sum_ready = 1'b1;

        // Reset mid-track discards the partial sum.
        send(0, 3, 0, w);
        send(0, 4, 0, w);
        ap_rst_n = 1'b0;
        #1;
        check("rst_mid_valid", sv38, 0);
        sync();
        ap_rst_n = 1'b1;
        push38(7, 1, 0);
        send(0, 7, 1, w);
        check("first_edge_accept", w, 0);

        // Drain the scoreboard with a bounded wait.
        for (int i = 0; i < 20 && (q38.size() != 0 || q32.size() != 0); i++) sync();
        check("q38_drained", q38.size(), 0);
        check("q32_drained", q32.size(), 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
